// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte image and
// writes it word by word into instruction memory. The processor is held in
// reset until the whole image has been written and its checksum matches.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      CSUM,
      RUN,
      ERROR
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_len_hi;
   logic [15:0] r_words_left;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_word;
   logic [7:0]  r_csum;
   logic [31:0] r_addr;

   logic        w_accept;
   logic [15:0] w_len;
   logic        w_len_over;

   assign w_accept   = byte_valid & byte_ready;
   assign w_len      = {r_len_hi, byte_data};
   assign w_len_over = ({16'd0, w_len} > MAX_WORDS);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LEN_HI;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived outputs; rst forces every output
   // to its idle value within the same cycle, not one edge later.
   always_comb begin
      w_state_nxt = r_state;
      byte_ready  = 1'b0;
      im_we       = 1'b0;
      cpu_rst     = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      im_addr     = r_addr;
      im_wdata    = r_word;

      case (r_state)
         LEN_HI: begin
            byte_ready = 1'b1;
            if (w_accept) w_state_nxt = LEN_LO;
         end
         LEN_LO: begin
            byte_ready = 1'b1;
            if (w_accept) begin
               if (w_len == 16'd0)  w_state_nxt = CSUM;
               else if (w_len_over) w_state_nxt = ERROR;
               else                 w_state_nxt = DATA;
            end
         end
         DATA: begin
            byte_ready = 1'b1;
            if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = WRITE;
         end
         WRITE: begin
            im_we       = 1'b1;
            w_state_nxt = (r_words_left > 16'd1) ? DATA : CSUM;
         end
         CSUM: begin
            byte_ready = 1'b1;
            if (w_accept) w_state_nxt = (byte_data == r_csum) ? RUN : ERROR;
         end
         RUN: begin
            cpu_rst = 1'b0;
            done    = 1'b1;
         end
         ERROR: begin
            error = 1'b1;
         end
         default: w_state_nxt = LEN_HI;
      endcase

      if (rst) begin
         byte_ready = 1'b0;
         im_we      = 1'b0;
         cpu_rst    = 1'b1;
         done       = 1'b0;
         error      = 1'b0;
         im_addr    = BASE_ADDR;
         im_wdata   = '0;
      end
   end

   // Datapath: length capture, word assembly, running checksum, write address.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_hi     <= '0;
         r_words_left <= '0;
         r_byte_cnt   <= '0;
         r_word       <= '0;
         r_csum       <= '0;
         r_addr       <= BASE_ADDR;
      end else begin
         case (r_state)
            LEN_HI: begin
               if (w_accept) begin
                  r_len_hi <= byte_data;
                  r_csum   <= r_csum ^ byte_data;
               end
            end
            LEN_LO: begin
               if (w_accept) begin
                  r_words_left <= w_len;
                  r_byte_cnt   <= '0;
                  r_csum       <= r_csum ^ byte_data;
               end
            end
            DATA: begin
               if (w_accept) begin
                  r_word     <= {r_word[23:0], byte_data};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_csum     <= r_csum ^ byte_data;
               end
            end
            WRITE: begin
               r_addr       <= r_addr + 32'd4;
               r_words_left <= r_words_left - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter: MAX_WORDS, default 256, maximum word count accepted in one image.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: byte_valid  input  1  source has a byte on byte_data.
REQ-006 Port: byte_data  input  8  incoming image byte.
REQ-007 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port: im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: im_addr  output  32  instruction-memory byte address, word-aligned.
REQ-010 Port: im_wdata  output  32  instruction word to write.
REQ-011 Port: cpu_rst  output  1  reset to processor; high until a valid image is loaded.
REQ-012 Port: done  output  1  image loaded and verified; processor released.
REQ-013 Port: error  output  1  sticky load failure.

Function
REQ-014 A byte SHALL be accepted on a rising edge where byte_valid and byte_ready are both 1; no other byte is consumed.
REQ-015 Image format SHALL be: length high byte, length low byte (16-bit word count N), then N words of 4 bytes each, most-significant byte first, then one checksum byte.
REQ-016 Checksum SHALL equal the XOR of every preceding image byte, length bytes included.
REQ-017 States SHALL be LEN_HI, LEN_LO, DATA, WRITE, CSUM, RUN, ERROR; byte_ready = 1 only in LEN_HI, LEN_LO, DATA, CSUM.
REQ-018 LEN_HI -> LEN_LO on accept; LEN_LO -> DATA if 1 <= N <= MAX_WORDS, -> CSUM if N = 0, -> ERROR if N > MAX_WORDS.
REQ-019 DATA: bytes shifted into a 32-bit word register; the 4th accepted byte moves to WRITE.
REQ-020 WRITE: lasts exactly one cycle; im_we = 1, im_wdata = assembled word, im_addr = BASE_ADDR + 4*k for the k-th word (k from 0); next state DATA if words remain, else CSUM.
REQ-021 im_addr SHALL advance by 4 after each WRITE and is 32-bit modulo arithmetic; im_we SHALL be 0 in every state other than WRITE.
REQ-022 CSUM: on accept, -> RUN if byte equals running XOR, else -> ERROR.
REQ-023 cpu_rst = 0 and done = 1 only in RUN; RUN and ERROR are terminal until rst; bytes are ignored there (byte_ready = 0).
REQ-024 error = 1 only in ERROR; cpu_rst stays 1 in ERROR; words already written are not rolled back.
REQ-025 Latency: cpu_rst falls and done rises in the cycle after the checksum byte is accepted; im_we asserts in the cycle after the 4th byte of a word is accepted.
REQ-026 byte_valid held during WRITE SHALL not be consumed; the byte is taken on the next DATA or CSUM cycle.

Reset
REQ-027 While rst = 1: state = LEN_HI, byte_ready = 0, im_we = 0, im_addr = BASE_ADDR, im_wdata = 0, cpu_rst = 1, done = 0, error = 0, checksum and word counter = 0.
REQ-028 rst asserted mid-load SHALL discard any partial word and count; the next load restarts at LEN_HI with im_addr = BASE_ADDR.
REQ-029 First cycle after rst deasserts: byte_ready = 1.

Verification
REQ-030 Stream 00 02 20 08 00 05 20 09 00 0A 0C, byte_valid always 1 -> writes 0x20080005 @0x0, 0x2009000A @0x4, then done = 1, cpu_rst = 0, error = 0.
REQ-031 Same stream with checksum 0x0D -> both writes occur, then error = 1, cpu_rst = 1, done = 0, byte_ready = 0.
REQ-032 Stream 00 00 00 -> no im_we pulses, done = 1 one cycle after third byte accepted.
REQ-033 Stream 01 01 (N = 257, MAX_WORDS = 256) -> error = 1 after second byte, no im_we ever.
REQ-034 REQ-030 stream with byte_valid toggling every other cycle -> identical write sequence and result; byte presented during WRITE is held and accepted one cycle later.
REQ-035 rst pulsed after 6 bytes of REQ-030, then full REQ-030 stream -> outputs at reset values during rst, final writes at 0x0/0x4, done = 1.
